// File: rtl/ex_muldiv_seq_pkg.sv
// Shared RV32M multiply/divide operation encodings, sequencer state encodings
// and operand-classification helpers.
package ex_muldiv_seq_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// ID/EX request and EX/MEM result bundle between the pipeline and the
// multiply/divide sequencer.
interface ex_muldiv_seq_if #(parameter int DATA_W = 32);

  logic [DATA_W-1:0] id_ex_reg_op_a_i;
  logic [DATA_W-1:0] id_ex_reg_op_b_i;
  logic [2:0]        id_ex_reg_md_op_i;
  logic              id_ex_reg_md_start_i;
  logic [4:0]        id_ex_reg_reg_waddr_i;
  logic              flush_i;
  logic              md_stall_o;
  logic [DATA_W-1:0] md_result_o;
  logic              md_valid_o;
  logic [4:0]        md_reg_waddr_o;
  logic              md_reg_we_o;

  modport master (
    output id_ex_reg_op_a_i, id_ex_reg_op_b_i, id_ex_reg_md_op_i,
           id_ex_reg_md_start_i, id_ex_reg_reg_waddr_i, flush_i,
    input  md_stall_o, md_result_o, md_valid_o, md_reg_waddr_o, md_reg_we_o
  );

  modport slave (
    input  id_ex_reg_op_a_i, id_ex_reg_op_b_i, id_ex_reg_md_op_i,
           id_ex_reg_md_start_i, id_ex_reg_reg_waddr_i, flush_i,
    output md_stall_o, md_result_o, md_valid_o, md_reg_waddr_o, md_reg_we_o
  );

endinterface

// File: rtl/ex_muldiv_seq_md_iter_step.sv
// One radix-2 iteration on the {hi,lo} accumulator: shift-add multiply
// (multiplier in lo, shifts right) or restoring divide (dividend in lo, shifts left).
module md_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic                  div_mode,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     opnd,
  output logic [2*DATA_W-1:0]   acc_next
);

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_part;
  logic [DATA_W-1:0] div_rem;
  logic              div_fits;

  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    // Partial remainder keeps the bit shifted out of hi, so it is DATA_W+1 wide.
    div_part = acc[2*DATA_W-1:DATA_W-1];
    div_fits = (div_part >= {1'b0, opnd});
    div_rem  = div_part[DATA_W-1:0] - opnd;
    if (div_mode) begin
      if (div_fits) acc_next = {div_rem, acc[DATA_W-2:0], 1'b1};
      else          acc_next = {div_part[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: stalls the front end while iterating
// one bit per cycle on operand magnitudes, then emits a one-cycle result toward EX/MEM.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_muldiv_seq_if.slave md
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  md_state_e           state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [4:0]          waddr_q;
  logic [DATA_W-1:0]   opnd_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] acc_nx;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot, rem, calc_res, spec_res;
  logic [DATA_W-1:0]   op_a, op_b, abs_a, abs_b;
  logic [DATA_W-1:0]   result_q;
  logic                valid_q, we_q;
  logic [4:0]          waddr_out_q;
  logic [2:0]          op_in;
  logic                neg_a, neg_b, neg_in, div_zero, div_ovf, go;

  assign op_a  = md.id_ex_reg_op_a_i;
  assign op_b  = md.id_ex_reg_op_b_i;
  assign op_in = md.id_ex_reg_md_op_i;
  assign go    = (state == MD_IDLE) && md.id_ex_reg_md_start_i && !md.flush_i;

  always_comb begin
    neg_a    = op_a_signed(op_in) & op_a[DATA_W-1];
    neg_b    = op_b_signed(op_in) & op_b[DATA_W-1];
    abs_a    = neg_a ? -op_a : op_a;
    abs_b    = neg_b ? -op_b : op_b;
    // Remainder takes the dividend's sign; everything else takes sign(a)^sign(b).
    neg_in   = (op_in == MD_REM) ? neg_a : (neg_a ^ neg_b);
    div_zero = op_is_div(op_in) && (op_b == '0);
    div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) && (op_a == MIN_NEG) && (op_b == '1);
    if (div_zero) spec_res = op_in[1] ? op_a : '1;
    else          spec_res = op_in[1] ? '0 : MIN_NEG;
  end

  md_iter_step #(.DATA_W(DATA_W)) u_step (
    .div_mode (op_is_div(op_q)),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_nx)
  );

  always_comb begin
    prod_fix = neg_q ? -acc_nx : acc_nx;
    quot     = neg_q ? -acc_nx[DATA_W-1:0] : acc_nx[DATA_W-1:0];
    rem      = neg_q ? -acc_nx[2*DATA_W-1:DATA_W] : acc_nx[2*DATA_W-1:DATA_W];
    case (op_q)
      MD_MUL:                      calc_res = prod_fix[DATA_W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod_fix[2*DATA_W-1:DATA_W];
      MD_DIV, MD_DIVU:             calc_res = quot;
      default:                     calc_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MD_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      waddr_q     <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      waddr_out_q <= '0;
    end else begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (go) begin
            op_q    <= op_in;
            neg_q   <= neg_in;
            waddr_q <= md.id_ex_reg_reg_waddr_i;
            if (div_zero || div_ovf) begin
              state       <= MD_DONE;
              result_q    <= spec_res;
              valid_q     <= 1'b1;
              we_q        <= (md.id_ex_reg_reg_waddr_i != '0);
              waddr_out_q <= md.id_ex_reg_reg_waddr_i;
            end else begin
              state  <= MD_CALC;
              cnt    <= CNT_W'(DATA_W-1);
              opnd_q <= op_is_div(op_in) ? abs_b : abs_a;
              acc_q  <= {{DATA_W{1'b0}}, (op_is_div(op_in) ? abs_a : abs_b)};
            end
          end
        end
        MD_CALC: begin
          if (md.flush_i) begin
            state <= MD_IDLE;
          end else begin
            acc_q <= acc_nx;
            cnt   <= cnt - 1'b1;
            if (cnt == '0) begin
              state       <= MD_DONE;
              result_q    <= calc_res;
              valid_q     <= 1'b1;
              we_q        <= (waddr_q != '0);
              waddr_out_q <= waddr_q;
            end
          end
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign md.md_stall_o     = go || (state == MD_CALC);
  assign md.md_result_o    = result_q;
  assign md.md_valid_o     = valid_q;
  assign md.md_reg_we_o    = we_q;
  assign md.md_reg_waddr_o = waddr_out_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Randomized bench for ex_muldiv_seq against a cycle-level arithmetic model
// of RV32M results, latencies and stall windows.
module tb_ex_muldiv_seq;
  import ex_muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_seq_if #(.DATA_W(32)) bus ();

  ex_muldiv_seq #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          pend = 1'b0;
  bit          kill = 1'b0;
  int          st = 0;
  int          due = 0;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_waddr = '0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Single compare process: every cycle, DUT outputs against the model's view.
  always @(negedge clk) begin
    logic ev, es;
    if (cyc == 2) begin
      check("pin_mul",    model(MD_MUL,    32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      check("pin_mulh",   model(MD_MULH,   32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
      check("pin_mulhu",  model(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      check("pin_mulhsu", model(MD_MULHSU, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
      check("pin_div",    model(MD_DIV,    32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("pin_rem",    model(MD_REM,    32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      check("pin_remu0",  model(MD_REMU,   32'd5, 32'd0), 32'd5);
      check("pin_lat",    latency(MD_DIVU, 32'd5, 32'd0), 32'd1);
    end
    if (!rst_n) begin
      check("rst_valid",  bus.md_valid_o, 0);
      check("rst_we",     bus.md_reg_we_o, 0);
      check("rst_waddr",  bus.md_reg_waddr_o, 0);
      check("rst_result", bus.md_result_o, 0);
      check("rst_stall",  bus.md_stall_o, 0);
    end else begin
      ev = pend && !kill && (cyc == due);
      es = pend && (cyc >= st) && (cyc < due);
      check("stall", bus.md_stall_o, es);
      check("valid", bus.md_valid_o, ev);
      check("we",    bus.md_reg_we_o, ev && (exp_waddr != 0));
      if (ev) begin
        check("result", bus.md_result_o, exp_res);
        check("waddr",  bus.md_reg_waddr_o, exp_waddr);
      end else begin
        check("hold", bus.md_result_o, last_res);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic start);
    bus.id_ex_reg_md_op_i    = op;
    bus.id_ex_reg_op_a_i     = a;
    bus.id_ex_reg_op_b_i     = b;
    bus.id_ex_reg_reg_waddr_i = wa;
    bus.id_ex_reg_md_start_i = start;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input bit noise);
    int lat;
    lat       = latency(op, a, b);
    exp_res   = model(op, a, b);
    exp_waddr = wa;
    st        = cyc;
    due       = cyc + lat;
    pend      = 1'b1;
    drive(op, a, b, wa, 1'b1);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (noise && k < lat) drive(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), 1'b1);
      else                  bus.id_ex_reg_md_start_i = 1'b0;
    end
    tick();
    pend     = 1'b0;
    last_res = exp_res;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    drive(MD_MUL, 0, 0, 0, 1'b0);
    bus.flush_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run_op(MD_MUL,    32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    run_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0);
    run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd8, 1'b1);
    run_op(MD_DIV,    32'hFFFF_FFF9, 32'd2, 5'd9, 1'b0);
    run_op(MD_REM,    32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
    run_op(MD_DIVU,   32'd5, 32'd0, 5'd11, 1'b0);
    run_op(MD_REMU,   32'd5, 32'd0, 5'd12, 1'b0);
    run_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
    run_op(MD_MUL,    32'd9, 32'd9, 5'd0, 1'b0);

    // Flush while idle: start must be ignored.
    drive(MD_MUL, 32'd2, 32'd2, 5'd3, 1'b1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.id_ex_reg_md_start_i = 1'b0;
    tick();

    // Flush in the 10th CALC cycle: nothing commits, stall drops next cycle.
    st = cyc; due = cyc + 33; pend = 1'b1; kill = 1'b1;
    drive(MD_MUL, $urandom, $urandom, 5'd4, 1'b1);
    tick();
    bus.id_ex_reg_md_start_i = 1'b0;
    repeat (9) tick();
    bus.flush_i = 1'b1;
    due = cyc + 1;
    tick();
    bus.flush_i = 1'b0;
    pend = 1'b0; kill = 1'b0;
    tick();
    run_op(MD_MUL, 32'd3, 32'd4, 5'd15, 1'b0);

    // Reset in mid-CALC: outputs clear without waiting for a clock edge.
    st = cyc; due = cyc + 33; pend = 1'b1;
    drive(MD_DIVU, $urandom, 32'd3, 5'd16, 1'b1);
    tick();
    bus.id_ex_reg_md_start_i = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    pend = 1'b0;
    last_res = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)),
             bit'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
